m3_speed_ramp_seq: RTL and testbench
====================================

M3_SPEED_RAMP_SEQ -- requirements
Module: m3_speed_ramp_seq

Interface
REQ-001 Parameters: PERIOD_MAX, 32'd1000000, slowest period (calc saturation); TICK_DIV, 4'd1, ticks per nextCalc pulse (1..15); RAMP_TMO, 16'd4096, max nextCalc pulses allowed in a ramp state.
REQ-002 clkI  in  1  sole clock; all logic on rising edge.
REQ-003 rstI  in  1  synchronous, active-high reset.
REQ-004 tick100hzI  in  1  one-cycle 100 Hz strobe.
REQ-005 btnIncI / btnDecI / btnInvI / btnStopI  in  1 each  level requests (inc, dec, reverse, stop).
REQ-006 curLenI  in  32  current period from the inc/dec calculator.
REQ-007 workingO  out 1  calculator enable; nextCalcO  out 1  one-cycle calc strobe.
REQ-008 speedIncO / speedDecO  out 1 each  levels to the calculator; invRotateO  out 1  direction.
REQ-009 forceStopO  out 1  stop in progress; faultO  out 1  sticky ramp timeout; stateO  out 3  state code.

Function
REQ-010 Each btn input SHALL pass a sync register (d1) and a history register (d2); edge = d1 & ~d2; the state register updates on the edge cycle, so stateO changes 2 cycles after the input rises.
REQ-011 States/codes: IDLE 0, RUN 1, REV_DECEL 2, REV_FLIP 3, REV_ACCEL 4, STOP_DECEL 5.
REQ-012 Edge priority in one cycle: stop > inv > inc > dec; lower-priority edges that cycle are discarded.
REQ-013 IDLE: workingO=0, speedIncO=speedDecO=0; inc edge -> RUN, clear faultO; inv edge toggles invRotateO, stays IDLE; stop/dec edges ignored.
REQ-014 RUN: workingO=1; speedIncO=d1(inc)&~d1(dec); speedDecO=d1(dec)&~d1(inc); both held -> both 0.
REQ-015 RUN inv edge: capture curLenI into savedLen, -> REV_DECEL.
REQ-016 REV_DECEL: speedDecO=1, speedIncO=0; when curLenI >= PERIOD_MAX -> REV_FLIP.
REQ-017 REV_FLIP: one cycle, toggle invRotateO, speedIncO=speedDecO=0, -> REV_ACCEL.
REQ-018 REV_ACCEL: speedIncO=1; when curLenI <= savedLen -> RUN.
REQ-019 Inv/inc/dec edges ignored in REV_DECEL, REV_FLIP, REV_ACCEL, STOP_DECEL; only stop edge acts.
REQ-020 Stop edge in any non-IDLE state -> STOP_DECEL; forceStopO=1 there; speedDecO=1; when curLenI >= PERIOD_MAX -> IDLE, forceStopO=0.
REQ-021 nextCalcO: while workingO=1, divider counts tick100hzI; pulse registered 1 cycle after every TICK_DIV-th tick; divider reloads TICK_DIV-1 in IDLE.
REQ-022 Ramp timeout: 16-bit counter clears on entry to REV_DECEL, REV_ACCEL, STOP_DECEL, increments per nextCalcO; reaching RAMP_TMO -> IDLE, faultO=1, workingO=0 next cycle.
REQ-023 curLenI compares are unsigned 32-bit; exit tests take precedence over the timeout in the same cycle.
REQ-024 workingO SHALL be 1 in every state except IDLE.

Reset
REQ-025 rstI=1: state IDLE, all outputs 0, savedLen=PERIOD_MAX, divider=TICK_DIV-1, timeout=0, d1/d2=0.
REQ-026 rstI mid-ramp SHALL abort the ramp; invRotateO returns to 0 regardless of direction.

Configuration
REQ-027 Macro M3_RAMP_HARD_STOP_EN: defined -> stop edge from any non-IDLE state goes straight to IDLE, forceStopO pulses 1 cycle, workingO=0 next cycle, no STOP_DECEL; undefined -> soft stop per REQ-020.

Verification
REQ-028 Reset, btnIncI high 3 cycles -> stateO 0->1 at cycle 2, workingO=1, speedIncO=1 while held.
REQ-029 RUN, curLenI=5000, btnInvI pulse -> REV_DECEL, speedDecO=1; curLenI=1000000 -> REV_FLIP 1 cycle, invRotateO toggles; curLenI=5000 -> RUN.
REQ-030 btnStopI and btnInvI rise same cycle in RUN -> STOP_DECEL, invRotateO unchanged (soft); with M3_RAMP_HARD_STOP_EN -> IDLE, forceStopO 1-cycle pulse.
REQ-031 TICK_DIV=3, RUN, 9 ticks -> exactly 3 nextCalcO pulses, each 1 cycle after ticks 3, 6, 9.
REQ-032 RAMP_TMO=4, REV_DECEL, curLenI held 100 -> after 4th nextCalcO: IDLE, faultO=1; next inc edge clears faultO.
REQ-033 btnIncI and btnDecI both held in RUN -> speedIncO=speedDecO=0; rstI in REV_ACCEL -> IDLE, invRotateO=0.

Source files
------------

// File: rtl/m3_speed_ramp_seq.sv
// m3_speed_ramp_seq
//   Motor speed ramp sequencer. It turns button requests (increase,
//   decrease, reverse, stop) into level controls for an external period
//   calculator, and paces that calculator with a divided 100 Hz strobe.
//   A reverse request decelerates to the slowest period, flips direction
//   and accelerates back to the period captured at the request. A stop
//   request decelerates to the slowest period and then idles. Each ramp
//   state is guarded by a timeout counted in calculator strobes; the
//   timeout drops to IDLE and raises a sticky fault.
//
// Ports
//   clkI        in   1   clock, rising edge
//   rstI        in   1   synchronous active-high reset
//   tick100hzI  in   1   one-cycle 100 Hz strobe
//   btnIncI     in   1   increase request (level)
//   btnDecI     in   1   decrease request (level)
//   btnInvI     in   1   reverse request (level, acts on rising edge)
//   btnStopI    in   1   stop request (level, acts on rising edge)
//   curLenI     in  32   current period from the calculator (unsigned)
//   workingO    out  1   calculator enable (every state except IDLE)
//   nextCalcO   out  1   one-cycle calculator strobe
//   speedIncO   out  1   shorten-period level to the calculator
//   speedDecO   out  1   lengthen-period level to the calculator
//   invRotateO  out  1   rotation direction
//   forceStopO  out  1   stop in progress
//   faultO      out  1   sticky ramp timeout
//   stateO      out  3   FSM state code (debug / checker visibility)
//
// Configuration
//   M3_RAMP_HARD_STOP_EN  defined: a stop edge from any non-IDLE state goes
//   straight to IDLE and forceStopO pulses for one cycle. Undefined: a stop
//   edge enters STOP_DECEL and forceStopO stays high until the period has
//   decayed to PERIOD_MAX.
//
// Strobe semantics: tick100hzI and nextCalcO carry no valid/ready
// handshake; each is a single-cycle strobe that the receiver must consume
// in the cycle it is high, there is no back-pressure.

module m3_speed_ramp_seq #(
  parameter logic [31:0] PERIOD_MAX = 32'd1000000,
  parameter logic [3:0]  TICK_DIV   = 4'd1,
  parameter logic [15:0] RAMP_TMO   = 16'd4096
) (
  input  logic        clkI,
  input  logic        rstI,
  input  logic        tick100hzI,
  input  logic        btnIncI,
  input  logic        btnDecI,
  input  logic        btnInvI,
  input  logic        btnStopI,
  input  logic [31:0] curLenI,
  output logic        workingO,
  output logic        nextCalcO,
  output logic        speedIncO,
  output logic        speedDecO,
  output logic        invRotateO,
  output logic        forceStopO,
  output logic        faultO,
  output logic [2:0]  stateO
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RUN        = 3'd1,
    REV_DECEL  = 3'd2,
    REV_FLIP   = 3'd3,
    REV_ACCEL  = 3'd4,
    STOP_DECEL = 3'd5
  } stateT;

`ifdef M3_RAMP_HARD_STOP_EN
  localparam stateT STOP_TARGET = IDLE;
`else
  localparam stateT STOP_TARGET = STOP_DECEL;
`endif

  stateT       state, stateNext;

  // Button synchronisers (d1) and history (d2). Decrease only ever acts as
  // a level in RUN; its edge has no effect anywhere, so it has no history.
  logic        incD1, incD2;
  logic        decD1;
  logic        invD1, invD2;
  logic        stopD1, stopD2;

  logic [31:0] savedLen;
  logic [3:0]  divCnt;
  logic        nextCalcQ;
  logic [15:0] tmoCnt;
  logic        invRotQ;
  logic        faultQ;

  // Edge detection with priority stop > inv > inc; lower edges in the same
  // cycle are discarded.
  logic        stopEdge, invEdge, incEdge;
  assign stopEdge = stopD1 & ~stopD2;
  assign invEdge  = invD1 & ~invD2 & ~stopEdge;
  assign incEdge  = incD1 & ~incD2 & ~stopEdge & ~(invD1 & ~invD2);

  logic        atMaxLen, backToSaved, tmoHit;
  assign atMaxLen    = curLenI >= PERIOD_MAX;
  assign backToSaved = curLenI <= savedLen;
  // The strobe that brings the count up to RAMP_TMO is the one that trips.
  assign tmoHit      = nextCalcQ && (({1'b0, tmoCnt} + 17'd1) >= {1'b0, RAMP_TMO});

  logic        isRamp, isRampNext, enterRamp;
  assign isRamp     = (state == REV_DECEL) || (state == REV_ACCEL) || (state == STOP_DECEL);
  assign isRampNext = (stateNext == REV_DECEL) || (stateNext == REV_ACCEL) ||
                      (stateNext == STOP_DECEL);
  assign enterRamp  = isRampNext && (stateNext != state);

  logic        loadSaved, flipDir, setFault, clrFault;

  // Next-state logic. Stop acts from every non-IDLE state ahead of all
  // other conditions; within a ramp state the exit test beats the timeout.
  always_comb begin
    stateNext = state;
    loadSaved = 1'b0;
    flipDir   = 1'b0;
    setFault  = 1'b0;
    clrFault  = 1'b0;
    if ((state != IDLE) && stopEdge) begin
      stateNext = STOP_TARGET;
    end else begin
      case (state)
        IDLE: begin
          if (incEdge) begin
            stateNext = RUN;
            clrFault  = 1'b1;
          end else if (invEdge) begin
            flipDir = 1'b1;
          end
        end
        RUN: begin
          if (invEdge) begin
            loadSaved = 1'b1;
            stateNext = REV_DECEL;
          end
        end
        REV_DECEL: begin
          if (atMaxLen) begin
            stateNext = REV_FLIP;
          end else if (tmoHit) begin
            stateNext = IDLE;
            setFault  = 1'b1;
          end
        end
        REV_FLIP: begin
          flipDir   = 1'b1;
          stateNext = REV_ACCEL;
        end
        REV_ACCEL: begin
          if (backToSaved) begin
            stateNext = RUN;
          end else if (tmoHit) begin
            stateNext = IDLE;
            setFault  = 1'b1;
          end
        end
        STOP_DECEL: begin
          if (atMaxLen) begin
            stateNext = IDLE;
          end else if (tmoHit) begin
            stateNext = IDLE;
            setFault  = 1'b1;
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Output decode from the current state.
  always_comb begin
    speedIncO = 1'b0;
    speedDecO = 1'b0;
    case (state)
      RUN: begin
        speedIncO = incD1 & ~decD1;
        speedDecO = decD1 & ~incD1;
      end
      REV_DECEL, STOP_DECEL: speedDecO = 1'b1;
      REV_ACCEL:             speedIncO = 1'b1;
      default: begin
        speedIncO = 1'b0;
        speedDecO = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      state     <= IDLE;
      incD1     <= 1'b0;
      incD2     <= 1'b0;
      decD1     <= 1'b0;
      invD1     <= 1'b0;
      invD2     <= 1'b0;
      stopD1    <= 1'b0;
      stopD2    <= 1'b0;
      savedLen  <= PERIOD_MAX;
      divCnt    <= TICK_DIV - 4'd1;
      nextCalcQ <= 1'b0;
      tmoCnt    <= 16'd0;
      invRotQ   <= 1'b0;
      faultQ    <= 1'b0;
    end else begin
      state  <= stateNext;
      incD1  <= btnIncI;
      incD2  <= incD1;
      decD1  <= btnDecI;
      invD1  <= btnInvI;
      invD2  <= invD1;
      stopD1 <= btnStopI;
      stopD2 <= stopD1;

      if (loadSaved) savedLen <= curLenI;
      if (flipDir)   invRotQ  <= ~invRotQ;

      if (setFault)      faultQ <= 1'b1;
      else if (clrFault) faultQ <= 1'b0;

      // Divider: the strobe is registered, so it appears the cycle after
      // every TICK_DIV-th tick.
      if (state == IDLE) begin
        divCnt    <= TICK_DIV - 4'd1;
        nextCalcQ <= 1'b0;
      end else if (tick100hzI) begin
        if (divCnt == 4'd0) begin
          divCnt    <= TICK_DIV - 4'd1;
          nextCalcQ <= 1'b1;
        end else begin
          divCnt    <= divCnt - 4'd1;
          nextCalcQ <= 1'b0;
        end
      end else begin
        nextCalcQ <= 1'b0;
      end

      if (enterRamp)               tmoCnt <= 16'd0;
      else if (isRamp && nextCalcQ) tmoCnt <= tmoCnt + 16'd1;
    end
  end

`ifdef M3_RAMP_HARD_STOP_EN
  logic hardStopQ;
  always_ff @(posedge clkI) begin
    if (rstI) hardStopQ <= 1'b0;
    else      hardStopQ <= (state != IDLE) && stopEdge;
  end
  assign forceStopO = hardStopQ;
`else
  assign forceStopO = (state == STOP_DECEL);
`endif

  assign workingO   = (state != IDLE);
  assign nextCalcO  = nextCalcQ;
  assign invRotateO = invRotQ;
  assign faultO     = faultQ;
  assign stateO     = state;

endmodule

// File: tb/tb_m3_speed_ramp_seq.sv
module tb_m3_speed_ramp_seq;

  logic        clkI = 1'b0;
  logic        rstI;
  logic        tick100hzI;
  logic        btnIncI, btnDecI, btnInvI, btnStopI;
  logic [31:0] curLenI;
  logic        workingO, nextCalcO, speedIncO, speedDecO;
  logic        invRotateO, forceStopO, faultO;
  logic [2:0]  stateO;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Clock / reset block
  always #5 clkI = ~clkI;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  m3_speed_ramp_seq #(
    .PERIOD_MAX(32'd1000000),
    .TICK_DIV  (4'd3),
    .RAMP_TMO  (16'd4)
  ) dut (
    .clkI      (clkI),
    .rstI      (rstI),
    .tick100hzI(tick100hzI),
    .btnIncI   (btnIncI),
    .btnDecI   (btnDecI),
    .btnInvI   (btnInvI),
    .btnStopI  (btnStopI),
    .curLenI   (curLenI),
    .workingO  (workingO),
    .nextCalcO (nextCalcO),
    .speedIncO (speedIncO),
    .speedDecO (speedDecO),
    .invRotateO(invRotateO),
    .forceStopO(forceStopO),
    .faultO    (faultO),
    .stateO    (stateO)
  );

  // Driver tasks: all inputs change and all outputs are sampled on negedge.
  task cyc(input int n);
    repeat (n) @(negedge clkI);
  endtask

  task do_reset;
    rstI = 1'b1;
    tick100hzI = 1'b0;
    btnIncI = 1'b0; btnDecI = 1'b0; btnInvI = 1'b0; btnStopI = 1'b0;
    curLenI = 32'd1000000;
    cyc(2);
    rstI = 1'b0;
  endtask

  task test_reset;
    do_reset;
    checks++; if (stateO !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", stateO); end
    checks++;
    if ({workingO, nextCalcO, speedIncO, speedDecO, invRotateO, forceStopO, faultO} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {workingO, nextCalcO, speedIncO, speedDecO, invRotateO, forceStopO, faultO});
    end
  endtask

  task test_inc_run;
    curLenI = 32'd5000;
    btnIncI = 1'b1;
    cyc(1);
    checks++; if (stateO !== 3'd0) begin errors++; $display("FAIL inc_state_c1: got %0d expected 0", stateO); end
    cyc(1);
    checks++; if (stateO !== 3'd1) begin errors++; $display("FAIL inc_state_c2: got %0d expected 1", stateO); end
    checks++; if (workingO !== 1'b1) begin errors++; $display("FAIL inc_working: got %b expected 1", workingO); end
    checks++; if (speedIncO !== 1'b1) begin errors++; $display("FAIL inc_speedinc_held: got %b expected 1", speedIncO); end
    cyc(1);
    btnIncI = 1'b0;
    cyc(1);
    checks++; if (speedIncO !== 1'b0) begin errors++; $display("FAIL inc_speedinc_release: got %b expected 0", speedIncO); end
    checks++; if (stateO !== 3'd1) begin errors++; $display("FAIL inc_stay_run: got %0d expected 1", stateO); end
  endtask

  task test_reverse;
    btnInvI = 1'b1;
    cyc(1);
    btnInvI = 1'b0;
    cyc(1);
    checks++; if (stateO !== 3'd2) begin errors++; $display("FAIL rev_decel_state: got %0d expected 2", stateO); end
    checks++; if ({speedIncO, speedDecO} !== 2'b01) begin errors++; $display("FAIL rev_decel_speed: got %b expected 01", {speedIncO, speedDecO}); end
    cyc(2);
    checks++; if (stateO !== 3'd2) begin errors++; $display("FAIL rev_decel_hold: got %0d expected 2", stateO); end
    curLenI = 32'd1000000;
    cyc(1);
    checks++; if (stateO !== 3'd3) begin errors++; $display("FAIL rev_flip_state: got %0d expected 3", stateO); end
    checks++; if ({speedIncO, speedDecO, invRotateO} !== 3'b000) begin errors++; $display("FAIL rev_flip_outs: got %b expected 000", {speedIncO, speedDecO, invRotateO}); end
    curLenI = 32'd20000;
    cyc(1);
    checks++; if (stateO !== 3'd4) begin errors++; $display("FAIL rev_accel_state: got %0d expected 4", stateO); end
    checks++; if ({speedIncO, invRotateO} !== 2'b11) begin errors++; $display("FAIL rev_accel_outs: got %b expected 11", {speedIncO, invRotateO}); end
    cyc(1);
    checks++; if (stateO !== 3'd4) begin errors++; $display("FAIL rev_accel_hold: got %0d expected 4", stateO); end
    curLenI = 32'd5000;
    cyc(1);
    checks++; if (stateO !== 3'd1) begin errors++; $display("FAIL rev_back_run: got %0d expected 1", stateO); end
  endtask

  task test_stop_inv;
    btnStopI = 1'b1;
    btnInvI  = 1'b1;
    cyc(1);
    btnStopI = 1'b0;
    btnInvI  = 1'b0;
    cyc(1);
`ifdef M3_RAMP_HARD_STOP_EN
    checks++; if (stateO !== 3'd0) begin errors++; $display("FAIL hstop_state: got %0d expected 0", stateO); end
    checks++; if ({forceStopO, workingO, invRotateO} !== 3'b101) begin errors++; $display("FAIL hstop_outs: got %b expected 101", {forceStopO, workingO, invRotateO}); end
    cyc(1);
    checks++; if (forceStopO !== 1'b0) begin errors++; $display("FAIL hstop_pulse_end: got %b expected 0", forceStopO); end
`else
    checks++; if (stateO !== 3'd5) begin errors++; $display("FAIL sstop_state: got %0d expected 5", stateO); end
    checks++; if ({forceStopO, speedDecO, workingO, invRotateO} !== 4'b1111) begin errors++; $display("FAIL sstop_outs: got %b expected 1111", {forceStopO, speedDecO, workingO, invRotateO}); end
    curLenI = 32'd1000000;
    cyc(1);
    checks++; if (stateO !== 3'd0) begin errors++; $display("FAIL sstop_idle: got %0d expected 0", stateO); end
    checks++; if ({forceStopO, workingO} !== 2'b00) begin errors++; $display("FAIL sstop_done_outs: got %b expected 00", {forceStopO, workingO}); end
`endif
  endtask

  // Scoreboard: each third tick pushes the cycle index where the strobe is due.
  task test_next_calc;
    int ticks, gap, pulses;
    logic due;
    do_reset;
    curLenI = 32'd5000;
    btnIncI = 1'b1;
    cyc(2);
    btnIncI = 1'b0;
    cyc(1);
    checks++; if (stateO !== 3'd1) begin errors++; $display("FAIL nc_run: got %0d expected 1", stateO); end
    exp_q.delete();
    ticks = 0; gap = 0; pulses = 0;
    for (int t = 0; t < 60; t++) begin
      due = (exp_q.size() > 0) && (exp_q[0] == 32'(t));
      if (due) void'(exp_q.pop_front());
      checks++;
      if (nextCalcO !== due) begin errors++; $display("FAIL nc_pulse cycle %0d: got %b expected %b", t, nextCalcO, due); end
      if (nextCalcO === 1'b1) pulses++;
      tick100hzI = 1'b0;
      if (ticks < 9 && gap == 0) begin
        tick100hzI = 1'b1;
        ticks++;
        if (ticks % 3 == 0) exp_q.push_back(32'(t + 1));
        gap = $urandom_range(1, 3);
      end else if (gap > 0) begin
        gap--;
      end
      cyc(1);
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL nc_count: got %0d expected 3", pulses); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL nc_left: got %0d pending expected 0", exp_q.size()); end
  endtask

  task test_timeout;
    do_reset;
    curLenI = 32'd100;
    btnIncI = 1'b1;
    cyc(1);
    btnIncI = 1'b0;
    cyc(2);
    btnInvI = 1'b1;
    cyc(1);
    btnInvI = 1'b0;
    cyc(1);
    checks++; if (stateO !== 3'd2) begin errors++; $display("FAIL tmo_decel: got %0d expected 2", stateO); end
    for (int i = 1; i <= 12; i++) begin
      tick100hzI = 1'b1;
      cyc(1);
      tick100hzI = 1'b0;
      if (i % 3 == 0) begin
        checks++; if (nextCalcO !== 1'b1) begin errors++; $display("FAIL tmo_strobe tick %0d: got %b expected 1", i, nextCalcO); end
      end
      if (i < 12) begin
        checks++; if (stateO !== 3'd2) begin errors++; $display("FAIL tmo_hold tick %0d: got %0d expected 2", i, stateO); end
        cyc($urandom_range(0, 2));
      end
    end
    checks++; if (stateO !== 3'd2) begin errors++; $display("FAIL tmo_last_strobe_state: got %0d expected 2", stateO); end
    cyc(1);
    checks++; if (stateO !== 3'd0) begin errors++; $display("FAIL tmo_idle: got %0d expected 0", stateO); end
    checks++; if ({faultO, workingO} !== 2'b10) begin errors++; $display("FAIL tmo_fault: got %b expected 10", {faultO, workingO}); end
    cyc(3);
    checks++; if (faultO !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b expected 1", faultO); end
    btnIncI = 1'b1;
    cyc(1);
    btnIncI = 1'b0;
    cyc(1);
    checks++; if ({stateO, faultO} !== 4'b0010) begin errors++; $display("FAIL tmo_clear: got %b expected 0010", {stateO, faultO}); end
  endtask

  task test_both_held;
    curLenI = 32'd5000;
    btnIncI = 1'b1;
    btnDecI = 1'b1;
    cyc(2);
    checks++; if ({stateO, speedIncO, speedDecO} !== 5'b00100) begin errors++; $display("FAIL both_held: got %b expected 00100", {stateO, speedIncO, speedDecO}); end
    btnIncI = 1'b0;
    cyc(1);
    checks++; if ({speedIncO, speedDecO} !== 2'b01) begin errors++; $display("FAIL dec_only: got %b expected 01", {speedIncO, speedDecO}); end
    btnDecI = 1'b0;
    cyc(1);
  endtask

  task test_reset_in_accel;
    btnInvI = 1'b1;
    cyc(1);
    btnInvI = 1'b0;
    cyc(1);
    curLenI = 32'd1000000;
    cyc(1);
    curLenI = 32'd20000;
    cyc(1);
    checks++; if ({stateO, invRotateO} !== 4'b1001) begin errors++; $display("FAIL accel_before_rst: got %b expected 1001", {stateO, invRotateO}); end
    rstI = 1'b1;
    cyc(1);
    rstI = 1'b0;
    checks++; if ({stateO, invRotateO, workingO} !== 5'b00000) begin errors++; $display("FAIL accel_rst: got %b expected 00000", {stateO, invRotateO, workingO}); end
  endtask

  initial begin
    test_reset;
    test_inc_run;
    test_reverse;
    test_stop_inv;
    test_next_calc;
    test_timeout;
    test_both_held;
    test_reset_in_accel;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
